even_parity_rx: RTL and testbench
=================================

// Module: even_parity_rx
// PURPOSE
//  Serial receiver/checker for 4-bit even-parity frames. It is the far end of the link
//  whose transmitter computes the even parity bit p over the data nibble.
//  Oversamples a 1-wire line, deframes start/data/parity/stop and recomputes parity.
//  Presents the word with parity_err/frame_err through a one-entry valid/ready buffer.
//  Sits between the board-level rxd pin and the lab display/checker logic.
// PARAMETERS
//  DATA_W  4  data bits per frame, LSB first
//  OS      8  clk cycles per bit (even, >=4); sample point = OS/2 into each bit
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  rxd         in   1       serial line, idle high, asynchronous to clk
//  rx_data     out  DATA_W  received word, stable while rx_valid=1
//  rx_valid    out  1       buffer holds a word
//  rx_ready    in   1       consumer accepts; transfer when rx_valid&&rx_ready
//  parity_err  out  1       ^{rx_data,parity bit}==1 for held word; valid with rx_valid
//  frame_err   out  1       stop bit sampled 0 for held word; valid with rx_valid
//  overrun     out  1       1-cycle pulse: completed frame dropped, buffer full
//  busy        out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
//    Reset also forces FSM=IDLE and sync flops=1. Reset mid-frame discards the frame.
//  - rxd passes a 2-flop synchronizer (rxd_s, 2-cycle lag). prev_s register is reset to 1.
//  - Frame: start(0), DATA_W data bits LSB first, even parity bit, stop(1).
//    Each bit is OS cycles long.
//  - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. Cycle counter cnt counts 0..OS-1.
//  - IDLE: prev_s=1 && rxd_s=0 (cycle t0) -> START, cnt=0.
//    A low line alone never triggers START.
//  - START: sample at t0+OS/2. If 0 -> DATA. If 1 (glitch) -> IDLE, no flags, no output.
//  - DATA: bit i sampled at t0+OS/2+(i+1)*OS and shifted in LSB first.
//    After DATA_W samples -> PARITY.
//  - PARITY: sample at t0+OS/2+(DATA_W+1)*OS. perr = ^shift ^ pbit.
//  - STOP: sample at t0+OS/2+(DATA_W+2)*OS. ferr = ~sample. Then -> IDLE immediately.
//    A 0 stop bit (break) does not retrigger until the line returns high.
//  - Load cycle is the cycle after the stop sample (defaults: t0+53).
//    - If the buffer is empty, or rx_valid&&rx_ready in that cycle: load rx_data/perr/ferr
//      and set rx_valid=1.
//    - Otherwise keep the old word and pulse overrun for 1 cycle.
//  - rx_valid&&rx_ready without a load: rx_valid->0 next cycle.
//    Flags hold their values until the next load.
//  - Parity or framing errors never block loading. The word is delivered with its flags.
//  - A new start edge is accepted in the IDLE cycle right after STOP (back-to-back frames).
// STRUCTURE
//  - parity_pkg: typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP} rx_state_t;
//    function even_parity(logic [DATA_W-1:0]).
//    The package is shared with the transmitter.
//  - Sub-module sync_2ff (1-bit, reset value parameter = 1) for rxd.
//    FSM, counters and buffer stay in this module.
// TESTING (OS=8, DATA_W=4; frame bits driven OS cycles each)
//  1. Send 0101, p=0, stop=1; rx_ready=1.
//     -> rx_valid at t0+53, rx_data=0101, parity_err=0, frame_err=0.
//  2. Send 1011, p=0 (wrong).
//     -> rx_data=1011, parity_err=1, frame_err=0.
//  3. Send 0011, p=0, stop=0, line then held low 40 cycles.
//     -> frame_err=1; no second frame; busy=0 after STOP.
//  4. rxd low 2 cycles only.
//     -> busy pulses, then IDLE; no rx_valid, no flags.
//  5. rx_ready=0; frames 1110(p=1) then 0001(p=1) back-to-back.
//     -> rx_data=1110 held, overrun pulse at frame-2 load.
//     Then rx_ready=1 -> 1110 consumed, rx_valid=0.
//  6. rst_n=0 during DATA bit 2.
//     -> all outputs 0, busy=0 asynchronously.
//     After release, send 1111 p=0 -> rx_data=1111, no errors.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity link: receiver state encoding,
// default frame geometry and the parity helper used by both link ends.
package parity_pkg;

  // Default frame geometry: data bits per frame and clk cycles per bit
  localparam int unsigned PAR_DATA_W = 4;
  localparam int unsigned PAR_OS     = 8;

  // Receiver deframing states, in frame order
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Even parity bit for a data word: 1 when the word holds an odd number of ones,
  // so that word plus parity bit always carries an even count of ones.
  function automatic logic even_parity(input logic [PAR_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/even_parity_rx_sync_2ff.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// The reset value is a parameter so an idle-high line stays idle through reset.
module sync_2ff #(
  parameter int unsigned         WIDTH   = 1,
  parameter logic [WIDTH-1:0]    RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; only sync_q is safe to use in clk logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/even_parity_rx.sv
// Even-parity serial receiver. Oversamples rxd by OS, deframes
// start / DATA_W data bits (LSB first) / parity / stop, and hands each word
// with its parity and framing flags to a one-entry valid/ready buffer.
module even_parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = PAR_DATA_W,
  parameter int unsigned OS     = PAR_OS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // Counter geometry. cnt counts cycles inside a bit; the START wait is half a
  // bit so every later sample lands OS/2 cycles into its bit.
  localparam int unsigned CNT_W = (OS > 1) ? $clog2(OS) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OS / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // Synchronized line and its previous value for falling-edge detection
  logic rxd_s;
  logic prev_q;

  // Deframer state
  rx_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              perr_q;

  // Output buffer
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              overrun_q;

  // Parity over the shifted-in data; uses the shared helper when widths agree
  logic data_par;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rxd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  generate
    if (DATA_W == PAR_DATA_W) begin : g_pkg_par
      assign data_par = even_parity(shift_q);
    end else begin : g_red_par
      assign data_par = ^shift_q;
    end
  endgenerate

  // Deframing FSM plus the one-entry output buffer, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q    <= rxd_s;
      overrun_q <= 1'b0;

      // Consumer handshake empties the buffer unless a load below refills it
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Only a genuine high-to-low transition starts a frame, so a line
          // stuck low after a break never retriggers.
          if (prev_q && !rxd_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line already back high mid-start-bit is a glitch: drop silently
            state_q <= rxd_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[DATA_W-1:1]};
            if (bit_q == BIT_LAST) begin
              state_q <= PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            perr_q  <= data_par ^ rxd_s;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            // Errored words are still delivered; only a full, unconsumed
            // buffer drops the frame.
            if (!rx_valid_q || rx_ready) begin
              rx_data_q    <= shift_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ~rxd_s;
              rx_valid_q   <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_even_parity_rx.sv
// Self-checking bench for even_parity_rx (DATA_W=4, OS=8).
// Expected flags come from counting ones in the transmitted frame fields.
module tb_even_parity_rx;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passed = 0;

  even_parity_rx #(.DATA_W(4), .OS(OS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: parity error when data plus parity bit carry an odd count of ones
  function automatic logic model_perr(input logic [3:0] d, input logic p);
    int ones;
    ones = p ? 1 : 0;
    for (int i = 0; i < 4; i++) if (d[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // Drives one frame starting just after a rising edge; observes rx_valid one
  // cycle before and at the expected delivery cycle (54/55 edges after start).
  task automatic run_frame(input logic [3:0] d, input logic p, input logic s,
                           input logic keep_low,
                           output logic v_before, output logic v_at,
                           output logic [3:0] rd, output logic pe,
                           output logic fe, output logic ov);
    logic [6:0] bits;
    logic       vb, va, pe_l, fe_l, ov_l;
    logic [3:0] rd_l;
    bits = {s, p, d, 1'b0};
    vb = 1'b0; va = 1'b0; pe_l = 1'b0; fe_l = 1'b0; ov_l = 1'b0; rd_l = '0;
    fork
      begin
        for (int k = 0; k < 7; k++) begin
          rxd = bits[k];
          repeat (OS) @(posedge clk);
          #1;
        end
        if (!keep_low) rxd = 1'b1;
      end
      begin
        repeat (54) @(posedge clk);
        #1 vb = rx_valid;
        @(posedge clk);
        #1;
        va = rx_valid; rd_l = rx_data; pe_l = parity_err; fe_l = frame_err; ov_l = overrun;
      end
    join
    v_before = vb; v_at = va; rd = rd_l; pe = pe_l; fe = fe_l; ov = ov_l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b1;
    #2;
    checks++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun, busy} !== 9'b0)
      $display("FAIL reset_outputs got=%b want=000000000",
               {rx_valid, rx_data, parity_err, frame_err, overrun, busy});
    else passed++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0)
      $display("FAIL reset_idle busy=%b valid=%b want 0/0", busy, rx_valid);
    else passed++;
    $display("reset: outputs cleared");
  endtask

  task automatic test_glitch();
    logic saw_valid, saw_flag;
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rxd = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL glitch_busy_rise got=%b want=1", busy);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL glitch_back_idle got=%b want=0", busy);
    else passed++;
    saw_valid = 1'b0; saw_flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (rx_valid) saw_valid = 1'b1;
      if (parity_err || frame_err || overrun) saw_flag = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0 || saw_flag !== 1'b0)
      $display("FAIL glitch_no_output valid_seen=%b flag_seen=%b want 0/0", saw_valid, saw_flag);
    else passed++;
    $display("glitch: 2-cycle low rejected");
  endtask

  task automatic test_good_frame();
    logic vb, va, pe, fe, ov;
    logic [3:0] rd;
    run_frame(4'b0101, 1'b0, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (vb !== 1'b0 || va !== 1'b1)
      $display("FAIL good_latency valid@52=%b valid@53=%b want 0/1", vb, va);
    else passed++;
    checks++;
    if (rd !== 4'b0101 || pe !== model_perr(4'b0101, 1'b0) || fe !== 1'b0)
      $display("FAIL good_word data=%b pe=%b fe=%b want 0101/0/0", rd, pe, fe);
    else passed++;
    $display("frame: data=%b p=0 stop=1 -> data=%b pe=%b fe=%b", 4'b0101, rd, pe, fe);
  endtask

  task automatic test_parity_err();
    logic vb, va, pe, fe, ov;
    logic [3:0] rd;
    run_frame(4'b1011, 1'b0, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (va !== 1'b1 || rd !== 4'b1011 || pe !== model_perr(4'b1011, 1'b0) || fe !== 1'b0)
      $display("FAIL parity_word valid=%b data=%b pe=%b fe=%b want 1/1011/1/0", va, rd, pe, fe);
    else passed++;
    $display("frame: data=1011 p=0 stop=1 -> data=%b pe=%b fe=%b", rd, pe, fe);
  endtask

  task automatic test_break();
    logic vb, va, pe, fe, ov, saw_busy, saw_valid;
    logic [3:0] rd;
    run_frame(4'b0011, 1'b0, 1'b0, 1'b1, vb, va, rd, pe, fe, ov);
    checks++;
    if (va !== 1'b1 || rd !== 4'b0011 || pe !== 1'b0 || fe !== 1'b1)
      $display("FAIL break_word valid=%b data=%b pe=%b fe=%b want 1/0011/0/1", va, rd, pe, fe);
    else passed++;
    saw_busy = 1'b0; saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
      if (rx_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || saw_valid !== 1'b0)
      $display("FAIL break_no_retrigger busy_seen=%b valid_seen=%b want 0/0", saw_busy, saw_valid);
    else passed++;
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("frame: data=0011 p=0 stop=0 (break) -> fe=%b", fe);
  endtask

  task automatic test_back_to_back();
    logic vb, va, pe, fe, ov;
    logic [3:0] rd;
    rx_ready = 1'b0;
    run_frame(4'b1110, 1'b1, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (va !== 1'b1 || rd !== 4'b1110 || pe !== model_perr(4'b1110, 1'b1) || ov !== 1'b0)
      $display("FAIL b2b_first valid=%b data=%b pe=%b ov=%b want 1/1110/0/0", va, rd, pe, ov);
    else passed++;
    run_frame(4'b0001, 1'b1, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (vb !== 1'b1 || va !== 1'b1 || rd !== 4'b1110 || ov !== 1'b1)
      $display("FAIL b2b_overrun held=%b valid=%b data=%b ov=%b want 1/1/1110/1", vb, va, rd, ov);
    else passed++;
    checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_one_cycle got=%b want=0", overrun);
    else passed++;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 4'b1110)
      $display("FAIL b2b_consume valid=%b data=%b want 0/1110", rx_valid, rx_data);
    else passed++;
    $display("back-to-back: 1110 held, 0001 dropped with overrun");
  endtask

  task automatic test_reset_midframe();
    logic vb, va, pe, fe, ov, saw_valid;
    logic [3:0] rd;
    logic [3:0] d;
    rx_ready = 1'b0;
    run_frame(4'b0110, 1'b1, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (va !== 1'b1 || pe !== 1'b1 || rd !== 4'b0110)
      $display("FAIL preload valid=%b data=%b pe=%b want 1/0110/1", va, rd, pe);
    else passed++;
    d = 4'b1010;
    rxd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (OS) @(posedge clk);
      #1 rxd = d[k];
    end
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1) $display("FAIL midframe_busy got=%b want=1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_valid, rx_data, parity_err, frame_err, overrun, busy} !== 9'b0)
      $display("FAIL midframe_reset got=%b want=000000000",
               {rx_valid, rx_data, parity_err, frame_err, overrun, busy});
    else passed++;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rx_valid || busy) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) $display("FAIL midframe_discarded activity=%b want=0", saw_valid);
    else passed++;
    run_frame(4'b1111, 1'b0, 1'b1, 1'b0, vb, va, rd, pe, fe, ov);
    checks++;
    if (va !== 1'b1 || rd !== 4'b1111 || pe !== 1'b0 || fe !== 1'b0)
      $display("FAIL after_reset_word valid=%b data=%b pe=%b fe=%b want 1/1111/0/0", va, rd, pe, fe);
    else passed++;
    $display("reset mid-frame: cleared, then data=%b pe=%b fe=%b", rd, pe, fe);
  endtask

  task automatic test_random();
    logic vb, va, pe, fe, ov;
    logic [3:0] rd, d;
    logic p, s, exp_pe;
    int gap;
    rx_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      d = 4'($urandom_range(0, 15));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      exp_pe = model_perr(d, p);
      run_frame(d, p, s, 1'b0, vb, va, rd, pe, fe, ov);
      checks++;
      if (vb !== 1'b0 || va !== 1'b1 || rd !== d || pe !== exp_pe || fe !== ~s || ov !== 1'b0)
        $display("FAIL random_%0d got v=%b/%b d=%b pe=%b fe=%b ov=%b want 0/1 d=%b pe=%b fe=%b ov=0",
                 n, vb, va, rd, pe, fe, ov, d, exp_pe, ~s);
      else passed++;
      $display("random %0d: data=%b p=%b stop=%b -> data=%b pe=%b fe=%b", n, d, p, s, rd, pe, fe);
      gap = s ? $urandom_range(0, 3) : $urandom_range(1, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_good_frame();
    test_parity_err();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
